// File: rtl/checker_pkg.sv
// Shared definitions for the response checker: sample width, FSM states and
// the helper that derives which stim codes a run must cover.
package checker_pkg;

    localparam int unsigned STIM_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_t;

    // Bits 0..min(n,8)-1 set: the stim codes a run of n samples must visit.
    function automatic logic [7:0] required_mask(input int unsigned n);
        logic [7:0] m;
        m = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < n) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/resp_ref_model.sv
// Combinational golden model of the checked block: out_1 is a 3-input AND,
// out_2 is (in_1 & in_2) | in_3.
module resp_ref_model
    import checker_pkg::*;
(
    input  logic [STIM_W-1:0] stim,
    output logic              exp1,
    output logic              exp2
);

    assign exp1 = stim[0] & stim[1] & stim[2];
    assign exp2 = (stim[0] & stim[1]) | stim[2];

endmodule

// File: rtl/response_checker.sv
// Runs NUM_VECTORS observed samples against resp_ref_model, counting
// mismatches, recording the first failing stim and the set of stim codes seen.
module response_checker
    import checker_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 8,
    parameter int unsigned ERR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [STIM_W-1:0] stim,
    input  logic              obs_out1,
    input  logic              obs_out2,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [STIM_W-1:0] first_err_stim,
    output logic              first_err_valid,
    output logic [7:0]        seen_mask
);

    localparam logic [7:0] REQ_MASK = required_mask(NUM_VECTORS);
    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

    state_t     state_q, state_d;
    logic [7:0] sample_cnt;

    logic       exp1, exp2;
    logic       start_run, accept, last_sample, mismatch;
    logic [ERR_W-1:0] err_next;
    logic [7:0] mask_next;

    resp_ref_model u_ref (
        .stim (stim),
        .exp1 (exp1),
        .exp2 (exp2)
    );

    always_comb begin
        start_run   = (state_q != CHECK) && start;
        accept      = (state_q == CHECK) && in_valid;
        last_sample = (sample_cnt == LAST_IDX);
        mismatch    = (obs_out1 != exp1) || (obs_out2 != exp2);
        mask_next   = seen_mask | (8'd1 << stim);
        err_next    = err_count;
        if (mismatch && (err_count != '1)) err_next = err_count + ERR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CHECK;
            CHECK:   if (accept && last_sample) state_d = DONE;
            DONE:    if (start) state_d = CHECK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Verdict is latched on the final accepting edge from the post-sample
    // values, so pass is valid in the same cycle done first rises.
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            sample_cnt      <= '0;
            err_count       <= '0;
            first_err_stim  <= '0;
            first_err_valid <= 1'b0;
            seen_mask       <= '0;
            pass            <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 8'd1;
            seen_mask  <= mask_next;
            err_count  <= err_next;
            if (mismatch && !first_err_valid) begin
                first_err_stim  <= stim;
                first_err_valid <= 1'b1;
            end
            if (last_sample) begin
                pass <= !mismatch && (err_count == '0)
                        && ((mask_next & REQ_MASK) == REQ_MASK);
            end
        end
    end

    assign busy = (state_q == CHECK);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_response_checker.sv
// Scoreboard bench for response_checker: a default instance and an ERR_W=2
// instance share the sample bus, each with its own start.
module tb_response_checker;

    logic       clk = 1'b0;
    logic       rst, start_a, start_b, in_valid, obs1, obs2;
    logic [2:0] stim;

    logic       busy_a, done_a, pass_a, fv_a;
    logic [7:0] err_a, mask_a;
    logic [2:0] fs_a;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [1:0] err_b;
    logic [7:0] mask_b;
    logic [2:0] fs_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] err;
        logic [2:0] fs;
        logic       fv;
        logic [7:0] mask;
        logic       pass;
    } res_t;

    res_t       sb[$];
    logic [2:0] v_stim[8];
    bit         v_bad1[8];
    bit         v_bad2[8];

    always #5 clk = ~clk;

    response_checker #(.NUM_VECTORS(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .stim(stim),
        .obs_out1(obs1), .obs_out2(obs2), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_stim(fs_a),
        .first_err_valid(fv_a), .seen_mask(mask_a)
    );

    response_checker #(.NUM_VECTORS(8), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .stim(stim),
        .obs_out1(obs1), .obs_out2(obs2), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_stim(fs_b),
        .first_err_valid(fv_b), .seen_mask(mask_b)
    );

    task automatic drive_sample(input logic [2:0] s, input bit b1, input bit b2);
        in_valid = 1'b1;
        stim     = s;
        obs1     = (s[0] & s[1] & s[2]) ^ b1;
        obs2     = ((s[0] & s[1]) | s[2]) ^ b2;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_expected(input bit sat);
        res_t r;
        int   nerr;
        int   cap;
        nerr   = 0;
        r.fv   = 1'b0;
        r.fs   = '0;
        r.mask = '0;
        for (int i = 0; i < 8; i++) begin
            r.mask[v_stim[i]] = 1'b1;
            if (v_bad1[i] || v_bad2[i]) begin
                nerr++;
                if (!r.fv) begin
                    r.fv = 1'b1;
                    r.fs = v_stim[i];
                end
            end
        end
        cap    = sat ? 3 : 255;
        r.err  = 8'((nerr > cap) ? cap : nerr);
        r.pass = (nerr == 0) && (r.mask == 8'hFF);
        sb.push_back(r);
    endtask

    task automatic collect(input bit sat, input string name);
        res_t       r;
        int         waited;
        logic       d, p, fv, bz;
        logic [7:0] e, m;
        logic [2:0] fs;
        waited = 0;
        while (!(sat ? done_b : done_a) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        r  = sb.pop_front();
        d  = sat ? done_b : done_a;
        bz = sat ? busy_b : busy_a;
        p  = sat ? pass_b : pass_a;
        fv = sat ? fv_b : fv_a;
        fs = sat ? fs_b : fs_a;
        e  = sat ? {6'b0, err_b} : err_a;
        m  = sat ? mask_b : mask_a;
        checks++;
        if (d !== 1'b1 || waited != 0) begin
            errors++;
            $display("FAIL %s done_latency: done=%b after %0d extra cycles, want done=1 after 0", name, d, waited);
        end
        checks++;
        if (bz !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 0", name, bz);
        end
        checks++;
        if (e !== r.err) begin
            errors++;
            $display("FAIL %s err_count: got %0d want %0d", name, e, r.err);
        end
        checks++;
        if (m !== r.mask) begin
            errors++;
            $display("FAIL %s seen_mask: got %h want %h", name, m, r.mask);
        end
        checks++;
        if (fv !== r.fv || (r.fv && fs !== r.fs)) begin
            errors++;
            $display("FAIL %s first_err: got valid=%b stim=%0d want valid=%b stim=%0d", name, fv, fs, r.fv, r.fs);
        end
        checks++;
        if (p !== r.pass) begin
            errors++;
            $display("FAIL %s pass: got %b want %b", name, p, r.pass);
        end
    endtask

    // Starts a run on one instance, optionally with a bogus sample on the start
    // cycle that must not be accepted, then plays the v_* table and scores it.
    task automatic run_vectors(input bit sat, input bit valid_on_start, input string name);
        push_expected(sat);
        if (sat) start_b = 1'b1;
        else     start_a = 1'b1;
        if (valid_on_start) begin
            in_valid = 1'b1;
            stim     = 3'd6;
            obs1     = 1'b1;
            obs2     = 1'b0;
        end
        @(negedge clk);
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) drive_sample(v_stim[i], v_bad1[i], v_bad2[i]);
        collect(sat, name);
    endtask

    task automatic set_table_correct();
        for (int i = 0; i < 8; i++) begin
            v_stim[i] = 3'(i);
            v_bad1[i] = 1'b0;
            v_bad2[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy_a, done_a, pass_a, err_a, fs_a, fv_a, mask_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got busy=%b done=%b pass=%b err=%0d fs=%0d fv=%b mask=%h want all 0",
                     busy_a, done_a, pass_a, err_a, fs_a, fv_a, mask_a);
        end
        checks++;
        if ({busy_b, done_b, pass_b, err_b, fs_b, fv_b, mask_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got busy=%b done=%b pass=%b err=%0d fs=%0d fv=%b mask=%h want all 0",
                     busy_b, done_b, pass_b, err_b, fs_b, fv_b, mask_b);
        end
    endtask

    task automatic test_all_pass();
        set_table_correct();
        run_vectors(1'b0, 1'b0, "all_pass");
    endtask

    task automatic test_one_error();
        set_table_correct();
        v_bad1[7] = 1'b1;
        run_vectors(1'b0, 1'b0, "one_error");
    endtask

    task automatic test_same_stim();
        set_table_correct();
        for (int i = 0; i < 8; i++) v_stim[i] = 3'd3;
        run_vectors(1'b0, 1'b0, "same_stim");
    endtask

    task automatic test_saturate();
        logic [2:0] order[8] = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6, 3'd7};
        for (int i = 0; i < 8; i++) begin
            v_stim[i] = order[i];
            v_bad1[i] = 1'b0;
            v_bad2[i] = 1'b1;
        end
        run_vectors(1'b1, 1'b0, "saturate");
    endtask

    task automatic test_reset_mid_run();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        drive_sample(3'd0, 1'b0, 1'b0);
        drive_sample(3'd1, 1'b0, 1'b1);
        drive_sample(3'd2, 1'b0, 1'b0);
        drive_sample(3'd3, 1'b0, 1'b0);
        checks++;
        if (busy_a !== 1'b1 || err_a !== 8'd1) begin
            errors++;
            $display("FAIL mid_run_state: got busy=%b err=%0d want busy=1 err=1", busy_a, err_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy_a, done_a, pass_a, err_a, fs_a, fv_a, mask_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b pass=%b err=%0d fs=%0d fv=%b mask=%h want all 0",
                     busy_a, done_a, pass_a, err_a, fs_a, fv_a, mask_a);
        end
        set_table_correct();
        run_vectors(1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_ignored_controls();
        set_table_correct();
        push_expected(1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) drive_sample(v_stim[i], 1'b0, 1'b0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || mask_a !== 8'h07 || err_a !== 8'd0) begin
            errors++;
            $display("FAIL start_in_check: got busy=%b mask=%h err=%0d want busy=1 mask=07 err=0", busy_a, mask_a, err_a);
        end
        for (int i = 3; i < 8; i++) drive_sample(v_stim[i], 1'b0, 1'b0);
        collect(1'b0, "start_in_check_run");
        drive_sample(3'd7, 1'b1, 1'b1);
        checks++;
        if (done_a !== 1'b1 || err_a !== 8'd0 || mask_a !== 8'hFF || pass_a !== 1'b1 || fv_a !== 1'b0) begin
            errors++;
            $display("FAIL valid_in_done: got done=%b err=%0d mask=%h pass=%b fv=%b want done=1 err=0 mask=ff pass=1 fv=0",
                     done_a, err_a, mask_a, pass_a, fv_a);
        end
    endtask

    task automatic test_back_to_back();
        set_table_correct();
        for (int i = 0; i < 8; i++) v_stim[i] = 3'(7 - i);
        run_vectors(1'b0, 1'b1, "back_to_back");
    endtask

    initial begin
        rst      = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        in_valid = 1'b0;
        stim     = '0;
        obs1     = 1'b0;
        obs2     = 1'b0;
        @(negedge clk);
        test_reset();
        test_all_pass();
        test_one_error();
        test_same_stim();
        test_saturate();
        test_reset_mid_run();
        test_ignored_controls();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/response_checker.md
RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 The module SHALL have parameter NUM_VECTORS, default 8, giving the number of samples checked per run (1..255).
REQ-002 The module SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a checking run.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the stim, obs_out1 and obs_out2 ports carry a sample this cycle.
REQ-007 The module SHALL have port stim, input, 3 bits: the stimulus applied to the DUT; bit0=in_1, bit1=in_2, bit2=in_3.
REQ-008 The module SHALL have port obs_out1, input, 1 bit: the observed DUT out_1.
REQ-009 The module SHALL have port obs_out2, input, 1 bit: the observed DUT out_2.
REQ-010 The module SHALL have port busy, output, 1 bit: high while in state CHECK.
REQ-011 The module SHALL have port done, output, 1 bit: high while in state DONE.
REQ-012 The module SHALL have port pass, output, 1 bit: the verdict, meaningful only while done=1.
REQ-013 The module SHALL have port err_count, output, ERR_W bits: the number of mismatching samples, saturating.
REQ-014 The module SHALL have port first_err_stim, output, 3 bits: the stim value of the first mismatching sample.
REQ-015 The module SHALL have port first_err_valid, output, 1 bit: first_err_stim holds a captured value.
REQ-016 The module SHALL have port seen_mask, output, 8 bits: bit k is set once stim==k has been checked in the current run.

Function
REQ-017 The expected outputs SHALL be exp1 = stim[0]&stim[1]&stim[2] and exp2 = (stim[0]&stim[1])|stim[2], evaluated against the observed outputs in the same cycle as the sample.
REQ-018 The state machine SHALL have exactly three states: IDLE, CHECK and DONE.
REQ-019 IDLE SHALL move to CHECK when start=1, and the same edge SHALL clear err_count, seen_mask, first_err_valid, first_err_stim and the internal sample counter.
REQ-020 In CHECK, each cycle with in_valid=1 SHALL be one accepted sample: increment the sample counter and set seen_mask[stim].
REQ-021 An accepted sample SHALL be a mismatch when obs_out1!=exp1 or obs_out2!=exp2.
REQ-022 A mismatch SHALL increment err_count, saturating at all-ones with no wrap.
REQ-023 The first mismatch of a run SHALL capture stim into first_err_stim and set first_err_valid; later mismatches SHALL not overwrite it.
REQ-024 All outputs SHALL be registered; err_count, seen_mask and first_err_* SHALL reflect a sample on the edge that accepts it (one-cycle latency).
REQ-025 The edge that accepts the NUM_VECTORS-th sample SHALL move CHECK to DONE, so done is high in the following cycle.
REQ-026 In DONE, pass SHALL be 1 iff err_count==0 and every seen_mask bit for stim values 0..min(NUM_VECTORS,8)-1 is set; otherwise pass SHALL be 0.
REQ-027 DONE SHALL hold all results until start=1, which behaves exactly as REQ-019 (back-to-back runs allowed).
REQ-028 in_valid SHALL be ignored in IDLE and DONE.
REQ-029 start SHALL be ignored in CHECK.
REQ-030 start and in_valid high together in IDLE SHALL start the run without accepting that cycle's sample.

Reset
REQ-031 When rst=1 the module SHALL enter IDLE and drive busy=0, done=0, pass=0, err_count=0, first_err_stim=0, first_err_valid=0 and seen_mask=0, from the first edge with rst high.
REQ-032 rst SHALL take priority over start and in_valid, and reset during CHECK SHALL abort the run with no result retained.

Structure
REQ-033 The state enum (IDLE/CHECK/DONE) and the constant STIM_W=3 SHALL be placed in a shared package named checker_pkg.
REQ-034 The expected-value computation SHALL be one combinational sub-module, resp_ref_model (stim in, exp1/exp2 out), so it can be reused by other benches.

Verification
REQ-035 The bench SHALL check: start, then 8 samples stim=0..7 with correct outputs -> done one cycle after the 8th, pass=1, err_count=0, seen_mask=8'hFF.
REQ-036 The bench SHALL check: same run with obs_out1 forced to 0 at stim=7 -> err_count=1, first_err_stim=3'd7, first_err_valid=1, pass=0.
REQ-037 The bench SHALL check: 8 correct samples all with stim=3 -> err_count=0, seen_mask=8'h08, pass=0.
REQ-038 The bench SHALL check: ERR_W=2 with 8 mismatching samples -> err_count saturates at 3, first_err_stim equals the first sample's stim.
REQ-039 The bench SHALL check: rst after 4 samples in CHECK -> next cycle IDLE with all outputs 0; a following start and 8 correct samples -> pass=1.
REQ-040 The bench SHALL check: start pulsed in CHECK and in_valid pulsed in DONE -> no effect on the counters or state.
